// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request per PC,
// holds the fetched word for decode, and steers the external PC register
// through next_pc (sequential +4, branch redirect, or reset vector).
// A redirect that arrives while a request is outstanding is remembered
// and applied when the memory acknowledges, so the bus address never moves
// mid-request.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN adds a sticky
// misaligned-fetch fault state and the misalign output.
module ifetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1
`ifdef IFETCH_MISALIGN_CHECK_EN
        ,
        S_FAULT = 2'd2
`endif
    } state_t;

    state_t      state, state_n;
    logic [31:0] instr_q, instr_n;
    logic        pend_q, pend_n;
    logic [31:0] ptgt_q, ptgt_n;
    logic        req_c, valid_c;
    logic [31:0] npc_c;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        outstanding_q;
    logic        misalign_c;
`endif

    // Next-state, datapath-next and output decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n = state;
        instr_n = instr_q;
        pend_n  = pend_q;
        ptgt_n  = ptgt_q;
        req_c   = 1'b0;
        valid_c = 1'b0;
        npc_c   = pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
        misalign_c = 1'b0;
`endif
        case (state)
            S_REQ: begin
                req_c = 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
                // Only a fresh fetch is checked; an outstanding request keeps going.
                if (!outstanding_q && (pc[1:0] != 2'b00)) begin
                    req_c = 1'b0;
                    if (redirect) npc_c = redirect_target;
                    else          state_n = S_FAULT;
                end else
`endif
                if (imem_ack) begin
                    if (redirect) begin
                        npc_c  = redirect_target;
                        pend_n = 1'b0;
                    end else if (pend_q) begin
                        npc_c  = ptgt_q;
                        pend_n = 1'b0;
                    end else begin
                        instr_n = imem_rdata;
                        state_n = S_VALID;
                    end
                end else if (redirect) begin
                    // Keep the bus address stable; apply the target on ack.
                    pend_n = 1'b1;
                    ptgt_n = redirect_target;
                end
            end
            S_VALID: begin
                valid_c = 1'b1;
                if (redirect) begin
                    npc_c   = redirect_target;
                    state_n = S_REQ;
                end else if (instr_ready) begin
                    npc_c   = pc + 32'd4;
                    state_n = S_REQ;
                end
            end
`ifdef IFETCH_MISALIGN_CHECK_EN
            S_FAULT: begin
                misalign_c = 1'b1;
                if (redirect) begin
                    npc_c   = redirect_target;
                    state_n = S_REQ;
                end
            end
`endif
            default: state_n = S_REQ;
        endcase

        if (rst) begin
            req_c   = 1'b0;
            valid_c = 1'b0;
            npc_c   = RESET_VECTOR;
`ifdef IFETCH_MISALIGN_CHECK_EN
            misalign_c = 1'b0;
`endif
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state   <= S_REQ;
            instr_q <= 32'h0;
            pend_q  <= 1'b0;
            ptgt_q  <= 32'h0;
        end else begin
            state   <= state_n;
            instr_q <= instr_n;
            pend_q  <= pend_n;
            ptgt_q  <= ptgt_n;
        end
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    // Tracks a request issued last cycle that has not yet been acknowledged.
    always_ff @(posedge clk) begin
        if (rst) outstanding_q <= 1'b0;
        else     outstanding_q <= req_c && !imem_ack;
    end

    assign misalign = misalign_c;
`endif

    assign imem_req    = req_c;
    assign imem_addr   = pc;
    assign next_pc     = npc_c;
    assign instr_valid = valid_c;
    assign instr       = rst ? 32'h0 : instr_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Table-driven bench for ifetch_unit. The bench owns the PC register
// (pc <= next_pc every rising edge) and compares combinational outputs
// one time unit after inputs change, away from the clock edge.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc = 32'h1234_5678;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_target;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;

    ifetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .next_pc         (next_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target)
`ifdef IFETCH_MISALIGN_CHECK_EN
        ,
        .misalign        (misalign)
`endif
    );

    always #5 clk = ~clk;

    // External PC register fed by next_pc.
    always @(posedge clk) pc <= next_pc;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_npc;
        logic        e_valid;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NVEC = 36;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic a, input logic [31:0] d,
                         input logic rd, input logic rq, input logic [31:0] t);
        rst = r; imem_ack = a; imem_rdata = d;
        instr_ready = rd; redirect = rq; redirect_target = t;
    endtask

    initial begin
        //             rst ack rdata         rdy rdr tgt            req addr          next_pc       vld instr
        vecs[0]  = '{1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0,       1'b0,32'h0};
        // back-to-back fetch, zero-delay ack, ready always high
        vecs[1]  = '{1'b0,1'b1,32'h00500093,1'b1,1'b0,32'h0,       1'b1,32'h0,       32'h0,       1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       1'b0,32'h0,       32'h4,       1'b1,32'h00500093};
        vecs[3]  = '{1'b0,1'b1,32'h00A00113,1'b1,1'b0,32'h0,       1'b1,32'h4,       32'h4,       1'b0,32'h00500093};
        vecs[4]  = '{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       1'b0,32'h4,       32'h8,       1'b1,32'h00A00113};
        vecs[5]  = '{1'b0,1'b1,32'h00500093,1'b1,1'b0,32'h0,       1'b1,32'h8,       32'h8,       1'b0,32'h00A00113};
        // decode stalls two cycles
        vecs[6]  = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b0,32'h8,       32'h8,       1'b1,32'h00500093};
        vecs[7]  = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b0,32'h8,       32'h8,       1'b1,32'h00500093};
        vecs[8]  = '{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       1'b0,32'h8,       32'hC,       1'b1,32'h00500093};
        // ack delayed three cycles
        vecs[9]  = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b1,32'hC,       32'hC,       1'b0,32'h00500093};
        vecs[10] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b1,32'hC,       32'hC,       1'b0,32'h00500093};
        vecs[11] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b1,32'hC,       32'hC,       1'b0,32'h00500093};
        vecs[12] = '{1'b0,1'b1,32'h11111111,1'b0,1'b0,32'h0,       1'b1,32'hC,       32'hC,       1'b0,32'h00500093};
        // redirect in VALID overrides ready
        vecs[13] = '{1'b0,1'b0,32'h0,       1'b1,1'b1,32'h100,     1'b0,32'hC,       32'h100,     1'b1,32'h11111111};
        vecs[14] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b1,32'h100,     32'h100,     1'b0,32'h11111111};
        // redirect in REQ without ack: pending, ack two cycles later discarded
        vecs[15] = '{1'b0,1'b0,32'h0,       1'b0,1'b1,32'h40,      1'b1,32'h100,     32'h100,     1'b0,32'h11111111};
        vecs[16] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b1,32'h100,     32'h100,     1'b0,32'h11111111};
        vecs[17] = '{1'b0,1'b1,32'hDEADBEEF,1'b0,1'b0,32'h0,       1'b1,32'h100,     32'h40,      1'b0,32'h11111111};
        vecs[18] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b1,32'h40,      32'h40,      1'b0,32'h11111111};
        // redirect together with ack: data dropped
        vecs[19] = '{1'b0,1'b1,32'hCAFEF00D,1'b0,1'b1,32'h80,      1'b1,32'h40,      32'h80,      1'b0,32'h11111111};
        vecs[20] = '{1'b0,1'b1,32'h22222222,1'b0,1'b0,32'h0,       1'b1,32'h80,      32'h80,      1'b0,32'h11111111};
        vecs[21] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b0,32'h80,      32'h80,      1'b1,32'h22222222};
        vecs[22] = '{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       1'b0,32'h80,      32'h84,      1'b1,32'h22222222};
        // two pending redirects: latest wins
        vecs[23] = '{1'b0,1'b0,32'h0,       1'b0,1'b1,32'h200,     1'b1,32'h84,      32'h84,      1'b0,32'h22222222};
        vecs[24] = '{1'b0,1'b0,32'h0,       1'b0,1'b1,32'h300,     1'b1,32'h84,      32'h84,      1'b0,32'h22222222};
        vecs[25] = '{1'b0,1'b1,32'h33333333,1'b0,1'b0,32'h0,       1'b1,32'h84,      32'h300,     1'b0,32'h22222222};
        vecs[26] = '{1'b0,1'b1,32'h44444444,1'b0,1'b0,32'h0,       1'b1,32'h300,     32'h300,     1'b0,32'h22222222};
        // PC wrap at the top of the address space
        vecs[27] = '{1'b0,1'b0,32'h0,       1'b0,1'b1,32'hFFFFFFFC,1'b0,32'h300,     32'hFFFFFFFC,1'b1,32'h44444444};
        vecs[28] = '{1'b0,1'b1,32'h55555555,1'b0,1'b0,32'h0,       1'b1,32'hFFFFFFFC,32'hFFFFFFFC,1'b0,32'h44444444};
        vecs[29] = '{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       1'b0,32'hFFFFFFFC,32'h0,       1'b1,32'h55555555};
        vecs[30] = '{1'b0,1'b1,32'h66666666,1'b0,1'b0,32'h0,       1'b1,32'h0,       32'h0,       1'b0,32'h55555555};
        vecs[31] = '{1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,       1'b0,32'h0,       32'h4,       1'b1,32'h66666666};
        // reset while a request is outstanding
        vecs[32] = '{1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b0,32'h4,       32'h0,       1'b0,32'h0};
        vecs[33] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b1,32'h0,       32'h0,       1'b0,32'h0};
        vecs[34] = '{1'b0,1'b1,32'h77777777,1'b0,1'b0,32'h0,       1'b1,32'h0,       32'h0,       1'b0,32'h0};
        vecs[35] = '{1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,       1'b0,32'h0,       32'h0,       1'b1,32'h77777777};

        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].redir, vecs[i].tgt);
            #1;
            check($sformatf("v%0d imem_req", i),    {31'h0, imem_req},    {31'h0, vecs[i].e_req});
            check($sformatf("v%0d imem_addr", i),   imem_addr,            vecs[i].e_addr);
            check($sformatf("v%0d next_pc", i),     next_pc,              vecs[i].e_npc);
            check($sformatf("v%0d instr_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d instr", i),       instr,                vecs[i].e_instr);
            tick();
        end

        // Hand sequence: redirect to a misaligned target (state VALID, pc 0).
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h102);
        #1;
        check("mis redirect next_pc", next_pc, 32'h102);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
`ifdef IFETCH_MISALIGN_CHECK_EN
        check("mis no req", {31'h0, imem_req}, 32'h0);
        tick();
        check("mis fault flag", {31'h0, misalign}, 32'h1);
        check("mis fault no req", {31'h0, imem_req}, 32'h0);
        check("mis fault next_pc", next_pc, 32'h102);
        tick();
        check("mis sticky", {31'h0, misalign}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
        #1;
        check("mis clear next_pc", next_pc, 32'h200);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("mis cleared", {31'h0, misalign}, 32'h0);
        check("mis refetch req", {31'h0, imem_req}, 32'h1);
        check("mis refetch addr", imem_addr, 32'h200);
`else
        check("unaligned req", {31'h0, imem_req}, 32'h1);
        check("unaligned addr", imem_addr, 32'h102);
        drive(1'b0, 1'b1, 32'h88888888, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("unaligned valid", {31'h0, instr_valid}, 32'h1);
        check("unaligned instr", instr, 32'h88888888);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: RESET_VECTOR, default 32'h00000000, value driven on next_pc during reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pc  input  32  current PC, from PC register output (newpc).
REQ-005 next_pc  output  32  PC for next cycle, to PC register input (oldpc); combinational.
REQ-006 imem_req  output  1  instruction-memory request, level.
REQ-007 imem_addr  output  32  fetch address, equals pc whenever imem_req=1.
REQ-008 imem_ack  input  1  memory response strobe; valid only while imem_req=1.
REQ-009 imem_rdata  input  32  instruction word, sampled when imem_ack=1.
REQ-010 instr  output  32  registered fetched instruction.
REQ-011 instr_valid  output  1  instr holds a live instruction for decode.
REQ-012 instr_ready  input  1  decode accepts instr this cycle.
REQ-013 redirect  input  1  branch/jump taken; one-cycle pulse.
REQ-014 redirect_target  input  32  new PC, sampled when redirect=1.
REQ-015 misalign  output  1  misaligned-fetch fault; present only with IFETCH_MISALIGN_CHECK_EN.

Function
REQ-016 FSM states: REQ, VALID, FAULT (FAULT only with macro); one-hot or binary at implementer's choice.
REQ-017 REQ: imem_req=1, imem_addr=pc, next_pc=pc; on imem_ack with no redirect pending, capture imem_rdata into instr, go VALID.
REQ-018 VALID: imem_req=0, instr_valid=1; on instr_ready, next_pc=pc+4 (mod 2^32, 32'hFFFFFFFC wraps to 0), go REQ; else next_pc=pc, stay.
REQ-019 Fetch latency: imem_ack in cycle N -> instr_valid=1 in cycle N+1; accept in cycle M -> imem_req for pc+4 in cycle M+1.
REQ-020 Redirect in VALID: instr_valid drops next cycle, next_pc=redirect_target, go REQ; redirect overrides simultaneous instr_ready (no pc+4).
REQ-021 Redirect in REQ with imem_ack same cycle: rdata discarded, next_pc=redirect_target, stay REQ.
REQ-022 Redirect in REQ without imem_ack: latch target into pending register, set pending flag, keep imem_req=1 and next_pc=pc (address stable).
REQ-023 While pending: imem_ack discards rdata, next_pc=pending target, clear flag, stay REQ; a further redirect overwrites pending target (latest wins).
REQ-024 imem_req never drops between assertion and imem_ack.
REQ-025 instr holds its value while instr_valid=1 and instr_ready=0.

Reset
REQ-026 While rst=1: state=REQ, imem_req=0, instr=0, instr_valid=0, pending flag=0, misalign=0, next_pc=RESET_VECTOR.
REQ-027 rst mid-fetch abandons outstanding request; first imem_req occurs cycle after rst deasserts, address=RESET_VECTOR.

Configuration
REQ-028 Macro IFETCH_MISALIGN_CHECK_EN defined: in REQ, if pc[1:0]!=0 and no request outstanding, no imem_req issued, go FAULT; misalign=1, next_pc=pc, sticky until redirect (-> REQ, target) or rst.
REQ-029 Macro undefined: no FAULT state, no misalign port, pc[1:0] passed unchanged on imem_addr.

Verification
REQ-030 Reset then ack with 0-cycle delay, rdata=32'h00500093, ready=1 each cycle -> instr_valid sequence, imem_addr 0,4,8,... next_pc increments by 4.
REQ-031 Ack delayed 3 cycles, instr_ready held 0 for 2 cycles -> imem_req held 3 cycles, pc stable, instr stable until accept.
REQ-032 Redirect to 32'h00000100 in VALID with instr_ready=1 -> next_pc=32'h100, no pc+4, instr_valid=0 next cycle, next imem_addr=32'h100.
REQ-033 Redirect to 32'h40 in REQ, ack 2 cycles later with rdata=32'hDEADBEEF -> rdata discarded, instr_valid stays 0, next fetch at 32'h40.
REQ-034 pc=32'hFFFFFFFC accepted -> next_pc=32'h00000000; with macro, redirect to 32'h00000102 -> misalign=1, no imem_req, cleared by redirect to 32'h200.
